pipe_mem: RTL and testbench
===========================

// Module: pipe_mem
// PURPOSE
//  Memory-access stage between pipe_EX and pipe_WB. Holds one instruction, waits for the data-SRAM
//  response (data_ok) of any load/store issued by EX, aligns and extends load data, and forwards
//  rf/csr/exception/tlb fields to WB. Discards stale responses of requests cancelled by a WB flush.
// PARAMETERS
//  DROP_W   2   width of stale-response counter (max outstanding cancelled requests = 2**DROP_W-1)
// PORTS
//  clk              in   1   clock
//  reset            in   1   synchronous, active-high reset
//  from_valid       in   1   EX holds a valid instruction ready to leave
//  from_pc          in   32  EX pc
//  to_allowin       out  1   MEM accepts EX data this cycle
//  to_valid         out  1   MEM data may leave to WB (valid & ready_go)
//  wb_allowin       in   1   WB accepts (tied 1 in current WB)
//  wb_flush         in   1   wb_ex | ertn_flush_out | tlb_flush_out from WB
//  mem_req_EX       in   1   EX issued a data-SRAM request (addr_ok seen) for this instruction
//  ld_op_EX         in   5   one-hot {ld_w, ld_hu, ld_h, ld_bu, ld_b}; 0 = not a load
//  vaddr_EX         in   32  data virtual address (low 2 bits select bytes; also bad vaddr)
//  rf_we_EX / rf_waddr_EX / rf_wdata_EX  in 1/5/32  ALU-side writeback fields
//  csr_bus_EX       in   80  {csr_num14, csr_en, csr_we, csr_wmask32, csr_wdata32}
//  misc_bus_EX      in   40  {ertn_flush, rd_cnt_op3, rd_timer32, tlbcommand3, tlb_flush}; 1+3+32+3+1
//  exc_src_EX       in   14  exception source vector, same bit order as WB
//  data_sram_data_ok in  1   response handshake
//  data_sram_rdata  in   32  response data
//  PC               out  32  registered pc to WB
//  rf_we_MEM/rf_waddr_MEM/rf_wdata_MEM  out 1/5/32  to WB; also forwarding source to ID
//  mem_ld_pending   out  1   valid load still waiting for data_ok (ID must stall, not forward)
//  csr_bus_MEM, misc_bus_MEM, exception_source_out, wb_vaddr_MEM  out 80/40/14/32  registered to WB
//  mem_ex_block     out  1   valid & (exc_src!=0 | ertn | tlb_flush): EX must not issue new requests
//  `ifdef MEM_PERF_CNT_EN: mem_stall_cnt  out 32  cycles spent waiting for data_ok
// BEHAVIOUR
//  - Reset: valid=0, all registered outputs 0, drop_cnt=0, data_buf_vld=0, mem_stall_cnt=0.
//  - to_allowin = ~valid | (ready_go & wb_allowin). On from_valid & to_allowin all *_EX latched.
//  - valid <= wb_flush ? 0 : (to_allowin ? from_valid : valid). Flush wins over incoming data.
//  - wait_data = valid & mem_req_r & ~data_buf_vld. ready_go = ~wait_data | (data_ok & drop_cnt==0).
//  - data_ok with drop_cnt!=0: response discarded, drop_cnt--; never reaches rf_wdata.
//  - data_ok & drop_cnt==0 & wait_data & ~(wb_allowin): rdata captured in data_buf, data_buf_vld=1;
//    cleared when instruction leaves or on flush.
//  - wb_flush while wait_data & ~(data_ok & drop_cnt==0): drop_cnt++ (saturate; assertion if full).
//    Flush in the same cycle as its own data_ok: response consumed, drop_cnt unchanged.
//  - Load data: rdata_sel = data_buf_vld ? data_buf : data_sram_rdata; byte = rdata_sel>>(8*vaddr[1:0]),
//    half = rdata_sel>>(16*vaddr[1]); ld_b/ld_h sign-extend, ld_bu/ld_hu zero-extend, ld_w as is.
//    rf_wdata_MEM = ld_op!=0 ? load_result : rf_wdata_r. Misaligned loads never reach here (ALE in EX).
//  - rf_we_MEM = rf_we_r & valid & exc_src_r==0. Store with exception: mem_req_EX is 0, no wait.
//  - Latency: 1 cycle when data_ok arrives in the first MEM cycle; +N for N cycles of response delay.
//  - mem_ld_pending = valid & ld_op!=0 & ~ready_go.
// CONFIGURATION
//  MEM_PERF_CNT_EN defined: mem_stall_cnt increments (wrapping at 2^32) every cycle wait_data & ~data_ok;
//  port exists. Undefined: counter and port absent; all other behaviour identical.
// STRUCTURE
//  define.v: LD_OP bit indices, CSR_BUS_W=80, MISC_BUS_W=40, EXC_SRC_W=14.
//  Sub-module mem_load_align (combinational: rdata, vaddr[1:0], ld_op -> 32-bit result).
// TESTING
//  - ld_b vaddr=0x..3, data_ok same cycle, rdata=0x80FF_1234 -> rf_wdata_MEM=0xFFFF_FF80, to_valid 1 cycle.
//  - ld_hu vaddr=0x..2, data_ok after 3 cycles, rdata=0x8001_0000 -> to_valid low 3 cycles, wdata=0x0000_8001,
//    mem_ld_pending high exactly those 3 cycles.
//  - Load waiting, wb_flush -> valid=0, drop_cnt=1; next data_ok (rdata=0xDEAD) discarded, new ld_w then
//    gets its own data_ok rdata=0x1111_2222 -> rf_wdata_MEM=0x1111_2222.
//  - wb_flush coincident with data_ok of waiting load -> drop_cnt stays 0, valid=0, rf_we_MEM=0.
//  - exc_src_EX=14'h0100 (ALE) with rf_we_EX=1 -> rf_we_MEM=0, mem_ex_block=1, exception_source_out=0x0100.
//  - wb_allowin=0 while data_ok arrives -> data_buf holds rdata; released intact when wb_allowin=1.

Source files
------------

// File: rtl/pipe_mem_pkg.sv
// Shared constants for the MEM pipeline stage: load-op bit positions and bus widths.
// Optional stall counter port on pipe_mem is enabled with MEM_PERF_CNT_EN.
package pipe_mem_pkg;
  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;
  localparam int LD_OP_W = 5;

  localparam int CSR_BUS_W  = 80;
  localparam int MISC_BUS_W = 40;
  localparam int EXC_SRC_W  = 14;

  // misc bus layout: {ertn_flush, rd_cnt_op[2:0], rd_timer[31:0], tlbcommand[2:0], tlb_flush}
  localparam int MISC_ERTN_BIT     = 39;
  localparam int MISC_TLBFLUSH_BIT = 0;
endpackage

// File: rtl/pipe_mem_load_align.sv
// Combinational load-data alignment: picks byte/half by address low bits and sign/zero-extends.
module pipe_mem_load_align
  import pipe_mem_pkg::*;
(
  input  logic [31:0]        rdata,
  input  logic [1:0]         addr_lo,
  input  logic [LD_OP_W-1:0] ld_op,
  output logic [31:0]        result
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(rdata >> {addr_lo, 3'b000});
  assign half_sel = 16'(rdata >> {addr_lo[1], 4'b0000});

  always_comb begin
    result = rdata;
    if (ld_op[LD_B])
      result = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op[LD_BU])
      result = {24'd0, byte_sel};
    else if (ld_op[LD_H])
      result = {{16{half_sel[15]}}, half_sel};
    else if (ld_op[LD_HU])
      result = {16'd0, half_sel};
  end
endmodule

// File: rtl/pipe_mem.sv
// Memory-access pipeline stage: waits for data-SRAM responses, aligns load data, forwards to WB.
// Define MEM_PERF_CNT_EN to add the mem_stall_cnt output.
module pipe_mem
  import pipe_mem_pkg::*;
#(
  parameter int DROP_W = 2
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  from_valid,
  input  logic [31:0]           from_pc,
  output logic                  to_allowin,
  output logic                  to_valid,
  input  logic                  wb_allowin,
  input  logic                  wb_flush,
  input  logic                  mem_req_EX,
  input  logic [LD_OP_W-1:0]    ld_op_EX,
  input  logic [31:0]           vaddr_EX,
  input  logic                  rf_we_EX,
  input  logic [4:0]            rf_waddr_EX,
  input  logic [31:0]           rf_wdata_EX,
  input  logic [CSR_BUS_W-1:0]  csr_bus_EX,
  input  logic [MISC_BUS_W-1:0] misc_bus_EX,
  input  logic [EXC_SRC_W-1:0]  exc_src_EX,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  output logic [31:0]           PC,
  output logic                  rf_we_MEM,
  output logic [4:0]            rf_waddr_MEM,
  output logic [31:0]           rf_wdata_MEM,
  output logic                  mem_ld_pending,
  output logic [CSR_BUS_W-1:0]  csr_bus_MEM,
  output logic [MISC_BUS_W-1:0] misc_bus_MEM,
  output logic [EXC_SRC_W-1:0]  exception_source_out,
  output logic [31:0]           wb_vaddr_MEM,
  output logic                  mem_ex_block
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]           mem_stall_cnt
`endif
);
  logic                  valid_reg;
  logic [31:0]           pc_reg;
  logic                  mem_req_reg;
  logic [LD_OP_W-1:0]    ld_op_reg;
  logic [31:0]           vaddr_reg;
  logic                  rf_we_reg;
  logic [4:0]            rf_waddr_reg;
  logic [31:0]           rf_wdata_reg;
  logic [CSR_BUS_W-1:0]  csr_bus_reg;
  logic [MISC_BUS_W-1:0] misc_bus_reg;
  logic [EXC_SRC_W-1:0]  exc_src_reg;
  logic [DROP_W-1:0]     drop_cnt_reg, drop_cnt_next;
  logic [31:0]           data_buf_reg;
  logic                  data_buf_vld_reg;

  logic wait_data, resp_ok, ready_go, leave;
  logic drop_inc, drop_dec, drop_full;
  logic [31:0] rdata_sel, load_result;

  // A response only belongs to us once every cancelled request ahead of it has been drained.
  assign resp_ok    = data_sram_data_ok & (drop_cnt_reg == '0);
  assign wait_data  = valid_reg & mem_req_reg & ~data_buf_vld_reg;
  assign ready_go   = ~wait_data | resp_ok;
  assign to_allowin = ~valid_reg | (ready_go & wb_allowin);
  assign to_valid   = valid_reg & ready_go;
  assign leave      = to_valid & wb_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      pc_reg       <= '0;
      mem_req_reg  <= 1'b0;
      ld_op_reg    <= '0;
      vaddr_reg    <= '0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      csr_bus_reg  <= '0;
      misc_bus_reg <= '0;
      exc_src_reg  <= '0;
    end else begin
      valid_reg <= wb_flush ? 1'b0 : (to_allowin ? from_valid : valid_reg);
      if (from_valid & to_allowin) begin
        pc_reg       <= from_pc;
        mem_req_reg  <= mem_req_EX;
        ld_op_reg    <= ld_op_EX;
        vaddr_reg    <= vaddr_EX;
        rf_we_reg    <= rf_we_EX;
        rf_waddr_reg <= rf_waddr_EX;
        rf_wdata_reg <= rf_wdata_EX;
        csr_bus_reg  <= csr_bus_EX;
        misc_bus_reg <= misc_bus_EX;
        exc_src_reg  <= exc_src_EX;
      end
    end
  end

  // Response arrived while WB is blocked: park it so the SRAM is not asked to hold it.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_buf_vld_reg <= 1'b0;
      data_buf_reg     <= '0;
    end else if (wb_flush | leave) begin
      data_buf_vld_reg <= 1'b0;
    end else if (resp_ok & wait_data & ~wb_allowin) begin
      data_buf_vld_reg <= 1'b1;
      data_buf_reg     <= data_sram_rdata;
    end
  end

  assign drop_dec  = data_sram_data_ok & (drop_cnt_reg != '0);
  assign drop_inc  = wb_flush & wait_data & ~resp_ok;
  assign drop_full = &drop_cnt_reg;

  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (drop_inc & ~drop_dec) begin
      if (!drop_full)
        drop_cnt_next = drop_cnt_reg + DROP_W'(1);
    end else if (drop_dec & ~drop_inc) begin
      drop_cnt_next = drop_cnt_reg - DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt_reg <= '0;
    else
      drop_cnt_reg <= drop_cnt_next;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(drop_inc && !drop_dec && drop_full));
  end

  assign rdata_sel = data_buf_vld_reg ? data_buf_reg : data_sram_rdata;

  pipe_mem_load_align u_align (
    .rdata   (rdata_sel),
    .addr_lo (vaddr_reg[1:0]),
    .ld_op   (ld_op_reg),
    .result  (load_result)
  );

  assign PC                   = pc_reg;
  assign rf_we_MEM            = rf_we_reg & valid_reg & (exc_src_reg == '0);
  assign rf_waddr_MEM         = rf_waddr_reg;
  assign rf_wdata_MEM         = (ld_op_reg != '0) ? load_result : rf_wdata_reg;
  assign mem_ld_pending       = valid_reg & (ld_op_reg != '0) & ~ready_go;
  assign csr_bus_MEM          = csr_bus_reg;
  assign misc_bus_MEM         = misc_bus_reg;
  assign exception_source_out = exc_src_reg;
  assign wb_vaddr_MEM         = vaddr_reg;
  assign mem_ex_block         = valid_reg & ((exc_src_reg != '0) | misc_bus_reg[MISC_ERTN_BIT]
                                             | misc_bus_reg[MISC_TLBFLUSH_BIT]);

`ifdef MEM_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_reg <= '0;
    else if (wait_data & ~data_sram_data_ok)
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end
  assign mem_stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_pipe_mem.sv
// Directed bench for pipe_mem: load alignment, response latency, flush/drop handling, WB backpressure.
module tb_pipe_mem;
  logic        clk = 1'b0;
  logic        reset;
  logic        from_valid;
  logic [31:0] from_pc;
  logic        to_allowin, to_valid;
  logic        wb_allowin, wb_flush;
  logic        mem_req_EX;
  logic [4:0]  ld_op_EX;
  logic [31:0] vaddr_EX;
  logic        rf_we_EX;
  logic [4:0]  rf_waddr_EX;
  logic [31:0] rf_wdata_EX;
  logic [79:0] csr_bus_EX;
  logic [39:0] misc_bus_EX;
  logic [13:0] exc_src_EX;
  logic        data_ok;
  logic [31:0] rdata;
  logic [31:0] PC;
  logic        rf_we_MEM;
  logic [4:0]  rf_waddr_MEM;
  logic [31:0] rf_wdata_MEM;
  logic        mem_ld_pending;
  logic [79:0] csr_bus_MEM;
  logic [39:0] misc_bus_MEM;
  logic [13:0] exception_source_out;
  logic [31:0] wb_vaddr_MEM;
  logic        mem_ex_block;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] mem_stall_cnt;
`endif

  localparam logic [4:0] OP_B  = 5'b00001;
  localparam logic [4:0] OP_H  = 5'b00100;
  localparam logic [4:0] OP_HU = 5'b01000;
  localparam logic [4:0] OP_W  = 5'b10000;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_mem dut (
    .clk                  (clk),
    .reset                (reset),
    .from_valid           (from_valid),
    .from_pc              (from_pc),
    .to_allowin           (to_allowin),
    .to_valid             (to_valid),
    .wb_allowin           (wb_allowin),
    .wb_flush             (wb_flush),
    .mem_req_EX           (mem_req_EX),
    .ld_op_EX             (ld_op_EX),
    .vaddr_EX             (vaddr_EX),
    .rf_we_EX             (rf_we_EX),
    .rf_waddr_EX          (rf_waddr_EX),
    .rf_wdata_EX          (rf_wdata_EX),
    .csr_bus_EX           (csr_bus_EX),
    .misc_bus_EX          (misc_bus_EX),
    .exc_src_EX           (exc_src_EX),
    .data_sram_data_ok    (data_ok),
    .data_sram_rdata      (rdata),
    .PC                   (PC),
    .rf_we_MEM            (rf_we_MEM),
    .rf_waddr_MEM         (rf_waddr_MEM),
    .rf_wdata_MEM         (rf_wdata_MEM),
    .mem_ld_pending       (mem_ld_pending),
    .csr_bus_MEM          (csr_bus_MEM),
    .misc_bus_MEM         (misc_bus_MEM),
    .exception_source_out (exception_source_out),
    .wb_vaddr_MEM         (wb_vaddr_MEM),
    .mem_ex_block         (mem_ex_block)
`ifdef MEM_PERF_CNT_EN
    ,
    .mem_stall_cnt        (mem_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    from_valid  = 1'b0;
    from_pc     = '0;
    mem_req_EX  = 1'b0;
    ld_op_EX    = '0;
    vaddr_EX    = '0;
    rf_we_EX    = 1'b0;
    rf_waddr_EX = '0;
    rf_wdata_EX = '0;
    csr_bus_EX  = '0;
    misc_bus_EX = '0;
    exc_src_EX  = '0;
  endtask

  task automatic drive_load(input logic [31:0] pc, input logic [4:0] op, input logic [31:0] va);
    from_valid  = 1'b1;
    from_pc     = pc;
    mem_req_EX  = 1'b1;
    ld_op_EX    = op;
    vaddr_EX    = va;
    rf_we_EX    = 1'b1;
    rf_waddr_EX = 5'd5;
    rf_wdata_EX = va;
  endtask

  initial begin
    clear_ex();
    reset = 1'b1; wb_allowin = 1'b1; wb_flush = 1'b0; data_ok = 1'b0; rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_to_valid", to_valid, 0);
    chk("rst_to_allowin", to_allowin, 1);
    chk("rst_pc", PC, 0);
    chk("rst_rf_we", rf_we_MEM, 0);
    chk("rst_wdata", rf_wdata_MEM, 0);
    chk("rst_pending", mem_ld_pending, 0);
    chk("rst_exblock", mem_ex_block, 0);
    chk("rst_exc", exception_source_out, 0);

    // ld_b, data_ok in first MEM cycle
    drive_load(32'h1000_0000, OP_B, 32'h0000_1003);
    #1 chk("ldb_allowin", to_allowin, 1);
    tick(); clear_ex();
    data_ok = 1'b1; rdata = 32'h80FF_1234;
    #1;
    chk("ldb_to_valid", to_valid, 1);
    chk("ldb_wdata", rf_wdata_MEM, 32'hFFFF_FF80);
    chk("ldb_rf_we", rf_we_MEM, 1);
    chk("ldb_waddr", rf_waddr_MEM, 5);
    chk("ldb_pc", PC, 32'h1000_0000);
    chk("ldb_pending", mem_ld_pending, 0);
    tick(); data_ok = 1'b0; rdata = '0;
    #1 chk("ldb_left", to_valid, 0);

    // ld_hu with 3 cycles of response delay
    drive_load(32'h1000_0004, OP_HU, 32'h0000_2002);
    tick(); clear_ex();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ldhu_wait_valid", to_valid, 0);
      chk("ldhu_wait_pending", mem_ld_pending, 1);
      tick();
    end
    data_ok = 1'b1; rdata = 32'h8001_0000;
    #1;
    chk("ldhu_to_valid", to_valid, 1);
    chk("ldhu_pending", mem_ld_pending, 0);
    chk("ldhu_wdata", rf_wdata_MEM, 32'h0000_8001);
`ifdef MEM_PERF_CNT_EN
    chk("ldhu_stall_cnt", mem_stall_cnt, 3);
`endif
    tick(); data_ok = 1'b0; rdata = '0;

    // Flush while waiting: the next response is stale and must be dropped
    drive_load(32'h1000_0008, OP_W, 32'h0000_3000);
    tick(); clear_ex();
    wb_flush = 1'b1;
    #1 chk("flush_pending_before", mem_ld_pending, 1);
    tick(); wb_flush = 1'b0;
    #1;
    chk("flush_valid", to_valid, 0);
    chk("flush_allowin", to_allowin, 1);
    chk("flush_pending", mem_ld_pending, 0);
    drive_load(32'h1000_000C, OP_W, 32'h0000_3004);
    tick(); clear_ex();
    data_ok = 1'b1; rdata = 32'h0000_DEAD;
    #1;
    chk("stale_to_valid", to_valid, 0);
    chk("stale_pending", mem_ld_pending, 1);
    tick();
    rdata = 32'h1111_2222;
    #1;
    chk("own_to_valid", to_valid, 1);
    chk("own_wdata", rf_wdata_MEM, 32'h1111_2222);
    chk("own_pc", PC, 32'h1000_000C);
    tick(); data_ok = 1'b0; rdata = '0;

    // Flush coincident with own data_ok: nothing left to drop
    drive_load(32'h1000_0010, OP_W, 32'h0000_4000);
    tick(); clear_ex();
    data_ok = 1'b1; rdata = 32'h3333_4444; wb_flush = 1'b1;
    tick(); data_ok = 1'b0; rdata = '0; wb_flush = 1'b0;
    #1;
    chk("coflush_valid", to_valid, 0);
    chk("coflush_rf_we", rf_we_MEM, 0);
    drive_load(32'h1000_0014, OP_W, 32'h0000_4004);
    tick(); clear_ex();
    data_ok = 1'b1; rdata = 32'h5555_6666;
    #1;
    chk("coflush_next_valid", to_valid, 1);
    chk("coflush_next_wdata", rf_wdata_MEM, 32'h5555_6666);
    tick(); data_ok = 1'b0; rdata = '0;

    // ALE-style exception on a load: no request, no writeback
    from_valid = 1'b1; from_pc = 32'h1000_0018; ld_op_EX = OP_H; vaddr_EX = 32'h0000_3001;
    rf_we_EX = 1'b1; rf_waddr_EX = 5'd7; exc_src_EX = 14'h0100;
    tick(); clear_ex();
    #1;
    chk("exc_rf_we", rf_we_MEM, 0);
    chk("exc_block", mem_ex_block, 1);
    chk("exc_src_out", exception_source_out, 14'h0100);
    chk("exc_to_valid", to_valid, 1);
    chk("exc_vaddr", wb_vaddr_MEM, 32'h0000_3001);
    tick();
    #1 chk("exc_block_clear", mem_ex_block, 0);

    // Non-memory instruction carrying ertn/tlb_flush and CSR fields
    from_valid = 1'b1; from_pc = 32'h1000_001C; rf_we_EX = 1'b1; rf_waddr_EX = 5'd9;
    rf_wdata_EX = 32'hABCD_0123; csr_bus_EX = 80'h1234_5678_9ABC_DEF0_1357;
    misc_bus_EX = 40'h80_0000_0001;
    tick(); clear_ex();
    #1;
    chk("alu_to_valid", to_valid, 1);
    chk("alu_rf_we", rf_we_MEM, 1);
    chk("alu_wdata", rf_wdata_MEM, 32'hABCD_0123);
    chk("alu_exblock", mem_ex_block, 1);
    chk("alu_csr", csr_bus_MEM, 80'h1234_5678_9ABC_DEF0_1357);
    chk("alu_misc", misc_bus_MEM, 40'h80_0000_0001);
    tick();

    // WB backpressure while data_ok arrives: response buffered and held
    drive_load(32'h6000_0000, OP_W, 32'h0000_5000);
    tick(); clear_ex();
    wb_allowin = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_F00D;
    #1;
    chk("bp_to_valid", to_valid, 1);
    chk("bp_allowin", to_allowin, 0);
    tick(); data_ok = 1'b0; rdata = '0;
    drive_load(32'h6000_0004, OP_W, 32'h0000_5004);
    #1;
    chk("bp_hold_valid", to_valid, 1);
    chk("bp_hold_wdata", rf_wdata_MEM, 32'hCAFE_F00D);
    chk("bp_hold_allowin", to_allowin, 0);
    tick();
    #1 chk("bp_hold_pc", PC, 32'h6000_0000);
    wb_allowin = 1'b1;
    #1;
    chk("bp_release_wdata", rf_wdata_MEM, 32'hCAFE_F00D);
    chk("bp_release_allowin", to_allowin, 1);
    tick(); clear_ex();
    #1;
    chk("bp_next_pc", PC, 32'h6000_0004);
    chk("bp_next_wait", to_valid, 0);
    chk("bp_next_pending", mem_ld_pending, 1);
    data_ok = 1'b1; rdata = 32'h7777_0001;
    #1;
    chk("bp_next_valid", to_valid, 1);
    chk("bp_next_wdata", rf_wdata_MEM, 32'h7777_0001);
    tick(); data_ok = 1'b0; rdata = '0;
    #1 chk("end_idle", to_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
